// File: rtl/ldst_pkg.sv
// Shared types for the load/store memory sequencer: FSM states and op encoding.
package ldst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/ldst_timeout_ctr.sv
// Cycle counter bounding the wait for a memory ack; used only when LDST_TIMEOUT_EN is defined.
module ldst_timeout_ctr #(
    parameter int TMO = 16
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(TMO);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == W'(TMO - 1));

endmodule

// File: rtl/ldst_mem_sequencer.sv
// Single-outstanding load/store sequencer between execute and data memory.
// Optional ack timeout with ERR state is enabled by defining LDST_TIMEOUT_EN.
module ldst_mem_sequencer
    import ldst_pkg::*;
#(
    parameter int n   = 4,
    parameter int AW  = 8,
    parameter int TMO = 16
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_op_valid,
    output logic          o_op_ready,
    input  logic          i_op_store,
    input  logic [AW-1:0] i_op_addr,
    input  logic [n-1:0]  i_op_wdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [n-1:0]  o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [n-1:0]  i_mem_rdata,
    output logic          o_ld_str,
    output logic [n-1:0]  o_ld_str_data,
    output logic          o_done,
    output logic          o_err
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_store;
    logic [AW-1:0] r_addr;
    logic [n-1:0]  r_wdata;
    logic [n-1:0]  r_rdata;

    logic w_accept;
    logic w_op_ready;
    logic w_mem_req;
    logic w_done;
    logic w_ld_str;
    logic w_err;
    logic w_expired;

    assign w_accept = (r_state == IDLE) && i_op_valid;

`ifdef LDST_TIMEOUT_EN
    ldst_timeout_ctr #(
        .TMO (TMO)
    ) u_timeout_ctr (
        .i_clk     (i_clk),
        .i_clr     (i_clr),
        .i_clear   (w_accept),
        .i_en      ((r_state == REQ) && !i_mem_ack),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= IDLE;
            r_store <= OP_LOAD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_store <= i_op_store;
                r_addr  <= i_op_addr;
                r_wdata <= i_op_wdata;
            end
            if ((r_state == REQ) && i_mem_ack && (r_store == OP_LOAD)) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_ready  = 1'b0;
        w_mem_req   = 1'b0;
        w_done      = 1'b0;
        w_ld_str    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                w_op_ready = 1'b1;
                if (i_op_valid) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_mem_req = 1'b1;
                // An ack arriving in the expiry cycle still completes normally.
                if (i_mem_ack) begin
                    w_state_nxt = DONE;
                end else if (w_expired) begin
                    w_state_nxt = ERR;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_ld_str    = (r_store == OP_LOAD);
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_err       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_op_ready    = w_op_ready;
    assign o_mem_req     = w_mem_req;
    assign o_mem_we      = w_mem_req && (r_store == OP_STORE);
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_wdata;
    assign o_ld_str      = w_ld_str;
    assign o_ld_str_data = r_rdata;
    assign o_done        = w_done;
`ifdef LDST_TIMEOUT_EN
    assign o_err         = w_err;
`else
    assign o_err         = 1'b0;
`endif

endmodule

// File: doc/ldst_mem_sequencer.md
# ldst_mem_sequencer

- Sequences one load or store at a time between the pipeline's execute stage and data memory.
- Accepts a request, runs a req/ack handshake with memory, and on load completion emits a one-cycle `ld_str` strobe plus data for the destination register-slice register.
- It is the producer side of the register's `ld_str` load interface.
- It sits between execute/writeback and the data-memory port.

## Interface
Parameters:
- `n`, 4: data width; matches destination register width.
- `AW`, 8: memory address width.
- `TMO`, 16: cycles to wait for `mem_ack` before abort. Used only with the timeout feature; must be ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `op_valid` in 1: request present.
- `op_ready` out 1: unit can accept a request; high only in IDLE.
- `op_store` in 1: 1 = store, 0 = load.
- `op_addr` in AW: memory address.
- `op_wdata` in n: store data.
- `mem_req` out 1: memory request; held until ack.
- `mem_we` out 1: write enable, valid with `mem_req`.
- `mem_addr` out AW: latched address.
- `mem_wdata` out n: latched store data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in n: read data, valid when `mem_ack` is high.
- `ld_str` out 1: one-cycle load strobe to the destination register.
- `ld_str_data` out n: load data, valid while `ld_str` is high.
- `done` out 1: one-cycle completion pulse; loads and stores.
- `err` out 1: one-cycle timeout pulse; tied 0 without the feature.

## Operation
States: IDLE, REQ, DONE, and ERR (ERR only with the timeout feature).
- **IDLE:** `op_ready`=1. When `op_valid`=1, latch `op_store`, `op_addr` and `op_wdata`, then go to REQ.
- **REQ:** `mem_req`=1. `mem_we`=latched store flag. `mem_addr`/`mem_wdata` come from the latches and stay stable for the whole state.
  - `mem_ack`=1: for a load, capture `mem_rdata` into the data register; go to DONE.
- **DONE:** `done`=1. For a load, also `ld_str`=1 and `ld_str_data` = captured data. Go to IDLE.
- **ERR:** `err`=1, no `ld_str`; go to IDLE.

Rules:
- `mem_ack` is ignored outside REQ.
- `op_valid` is ignored outside IDLE; no queuing.
- Reset: state IDLE. `mem_req`, `mem_we`, `ld_str`, `done`, `err` = 0. `mem_addr`, `mem_wdata`, `ld_str_data` = 0. Timeout counter = 0.
- Reset mid-operation abandons the transfer. No strobe is issued, and `mem_req` is low from the next cycle.

## Timing
- Accept edge is cycle 0; `mem_req` rises in cycle 1.
- If ack is sampled high in cycle k (k≥1), DONE is in cycle k+1: `ld_str`/`done` high for exactly one cycle. `op_ready` returns high in cycle k+2.
- Minimum accept-to-strobe latency: 2 cycles. Minimum issue interval: 3 cycles.
- `mem_req` deasserts in the cycle after ack is sampled.

## Configuration
- Macro `LDST_TIMEOUT_EN`.
- **Defined:** a counter clears on REQ entry and increments each REQ cycle without ack.
  - When the counter equals `TMO-1` with no ack, go to ERR; `err` pulses in the next cycle.
  - Ack in that same cycle wins: go to DONE.
- **Undefined:**
  - There is no counter and no ERR state, and `err` is tied 0.
  - REQ waits indefinitely.

## Structure
- Package `ldst_pkg` holds:
  - the state enum: IDLE, REQ, DONE, ERR;
  - the op encoding constants `OP_LOAD`=0 and `OP_STORE`=1.
- Sub-module `ldst_timeout_ctr` (width $clog2(TMO)) is instantiated only under `LDST_TIMEOUT_EN`. Ports: clear, enable, `expired`.
- Top level holds the FSM and the latches.

## Test plan
- **Load, immediate ack:** load addr 0x12, ack in cycle 1 with rdata 4'hA.
  - `ld_str`=1 with `ld_str_data`=4'hA in cycle 2.
  - `op_ready`=1 in cycle 3.
- **Store, delayed ack:** store 4'h5 to 0x34, ack in cycle 4.
  - `mem_we`=1, addr 0x34, wdata 4'h5 held through cycles 1–4.
  - `done`=1 in cycle 5, `ld_str` stays 0.
- **Spurious ack / busy request:** ack pulses in IDLE, and `op_valid` is held during REQ.
  - No state change, no extra request accepted.
  - Exactly one `done`.
- **Reset mid-REQ:** `clr` in cycle 2 of a load.
  - `mem_req`=0 in cycle 3, and `ld_str` never asserts.
  - Next request behaves normally.
- **Timeout (`LDST_TIMEOUT_EN`, TMO=4):** no ack.
  - `err` pulses once in cycle 5, no `ld_str`, IDLE in cycle 6.
  - With ack in cycle 4, `done` instead of `err`.
- **Back-to-back loads:** loads returning 4'h3 then 4'hC.
  - Two `ld_str` pulses carrying 4'h3 then 4'hC, at least 3 cycles apart.
